// File: rtl/pmod_i2c_pkg.sv
// Shared types and constants for the PMOD I2C register target.
package pmod_i2c_pkg;

    // Default 7-bit bus address of the target.
    localparam logic [6:0] DEFAULT_ADDR = 7'h52;

    // Protocol states of the target engine.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_e;

endpackage

// File: rtl/pmod_i2c_in_filter.sv
// Input conditioning for one asynchronous bus line: 2-FF synchronizer,
// optionally followed by a 3-sample majority filter.
// Optional feature macro: PMOD_I2C_TARGET_GLITCH_FILTER_EN
//   defined   -> majority filter present, 2 clk of extra latency
//   undefined -> synchronizer output used directly
module pmod_i2c_in_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    // Two-stage synchronizer, preset to the idle (released) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

`ifdef PMOD_I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] hist_reg;

    // History of the last three synchronized samples for the majority vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= 3'b111;
        end else begin
            hist_reg <= {hist_reg[1:0], sync_reg[1]};
        end
    end

    // A level must be present in two of three samples, so single-clk spikes vanish.
    assign dout = (hist_reg[0] & hist_reg[1]) |
                  (hist_reg[0] & hist_reg[2]) |
                  (hist_reg[1] & hist_reg[2]);
`else
    assign dout = sync_reg[1];
`endif

endmodule

// File: rtl/pmod_i2c_target.sv
// I2C register-target: address match, 8-bit register pointer, multi-byte
// writes with auto-increment and sequential reads from a parent register file.
// Optional feature macro: PMOD_I2C_TARGET_GLITCH_FILTER_EN (input majority filter).
module pmod_i2c_target
    import pmod_i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    // Bus line conditioning: index 0 = SCL, index 1 = SDA.
    logic [1:0] raw_bus;
    logic [1:0] filt_bus;
    assign raw_bus = {sda_i, scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            pmod_i2c_in_filter u_filt (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (raw_bus[gi]),
                .dout  (filt_bus[gi])
            );
        end
    endgenerate

    logic scl_s;
    logic sda_s;
    assign scl_s = filt_bus[0];
    assign sda_s = filt_bus[1];

    logic scl_prev_reg;
    logic sda_prev_reg;

    // Previous conditioned levels for edge and START/STOP detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    logic start_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;

    i2c_state_e state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       rw_reg, rw_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic       wr_strobe_reg, wr_strobe_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;

    // Byte as it will look once the bit on SDA now is shifted in.
    logic [7:0] byte_in;
    logic       last_bit_rise;
    assign byte_in       = {shift_reg[6:0], sda_s};
    assign last_bit_rise = scl_rise && (bit_cnt_reg == 4'd7);

    // Protocol state and datapath registers; reset releases SDA at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 8'h00;
            ptr_reg       <= 8'h00;
            rw_reg        <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 8'h00;
            wr_data_reg   <= 8'h00;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            rw_reg        <= rw_next;
            sda_oe_reg    <= sda_oe_next;
            busy_reg      <= busy_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ptr_next       = ptr_reg;
        rw_next        = rw_reg;
        sda_oe_next    = sda_oe_reg;
        busy_next      = busy_reg;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;

        if (stop_det) begin
            state_next   = ST_IDLE;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                    if (last_bit_rise) begin
                        bit_cnt_next = 4'd0;
                        if (state_reg == ST_ADDR) begin
                            if (byte_in[7:1] == ADDR) begin
                                busy_next  = 1'b1;
                                rw_next    = byte_in[0];
                                state_next = ST_ADDR_ACK;
                            end else begin
                                busy_next  = 1'b0;
                                state_next = ST_WAIT_STOP;
                            end
                        end else if (state_reg == ST_PTR) begin
                            ptr_next   = byte_in;
                            state_next = ST_PTR_ACK;
                        end else begin
                            wr_strobe_next = 1'b1;
                            wr_addr_next   = ptr_reg;
                            wr_data_next   = byte_in;
                            ptr_next       = ptr_reg + 8'd1;
                            state_next     = ST_WDATA_ACK;
                        end
                    end
                end

                // The first SCL fall after the 8th bit starts the ACK, the
                // next one ends it; sda_oe itself tells the two apart.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            if (state_reg == ST_ADDR_ACK) begin
                                if (rw_reg) begin
                                    shift_next  = rd_data;
                                    sda_oe_next = ~rd_data[7];
                                    state_next  = ST_RDATA;
                                end else begin
                                    state_next = ST_PTR;
                                end
                            end else begin
                                state_next = ST_WDATA;
                            end
                        end
                    end
                end

                // Rotate so the next bit to drive always sits in bit 7.
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next = 1'b0;
                            state_next  = ST_RDATA_ACK;
                        end else begin
                            shift_next  = {shift_reg[6:0], shift_reg[7]};
                            sda_oe_next = ~shift_reg[6];
                        end
                    end
                end

                // bit_cnt = 9 marks "host ACKed, load next byte on SCL fall".
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            sda_oe_next = 1'b0;
                            busy_next   = 1'b0;
                            state_next  = ST_WAIT_STOP;
                        end else begin
                            ptr_next     = ptr_reg + 8'd1;
                            bit_cnt_next = 4'd9;
                        end
                    end else if (scl_fall && (bit_cnt_reg == 4'd9)) begin
                        shift_next   = rd_data;
                        sda_oe_next  = ~rd_data[7];
                        bit_cnt_next = 4'd0;
                        state_next   = ST_RDATA;
                    end
                end

                default: begin
                    // IDLE and WAIT_STOP only react to START/STOP.
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign busy      = busy_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign rd_addr   = ptr_reg;

endmodule

// File: tb/tb_pmod_i2c_target.sv
// Self-checking bench for pmod_i2c_target: directed scenarios at ~100 kHz SCL
// with a ~12 MHz clk, then randomized transactions at a faster SCL, all
// checked against a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_pmod_i2c_target;
    import pmod_i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_h = 1'b1;
    logic       sda_h = 1'b1;
    logic       sda_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       sda_line;

    int checks = 0;
    int failures = 0;
    int q_clk = 30;

    // Open-drain SDA: either side pulling low wins.
    assign sda_line = sda_h & ~sda_oe;

    always #42 clk = ~clk;

    pmod_i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_h),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    // Default register contents before any write.
    function automatic logic [7:0] seed_val(input logic [7:0] a);
        logic [7:0] t;
        t = a * 8'd37;
        return t ^ 8'hC3;
    endfunction

    // Parent register file driving rd_data.
    logic [7:0]   parent_mem [256];
    logic [255:0] parent_wr = '0;
    always @(posedge clk) begin
        if (wr_strobe) begin
            parent_mem[wr_addr] <= wr_data;
            parent_wr[wr_addr]  <= 1'b1;
        end
    end
    assign rd_data = parent_wr[rd_addr] ? parent_mem[rd_addr] : seed_val(rd_addr);

    // Strobe monitor: {back-to-back flag, addr, data}.
    logic [16:0] got_q[$];
    logic        strobe_prev = 1'b0;
    always @(negedge clk) begin
        if (wr_strobe) got_q.push_back({strobe_prev, wr_addr, wr_data});
        strobe_prev = wr_strobe;
    end

    // Transaction-level model.
    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr = 8'h00;
    logic [15:0] exp_q[$];
    logic [7:0]  tx_q[$];
    int          got_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_q();
        repeat (q_clk) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_h = 1'b1; wait_q();
        scl_h = 1'b1; wait_q();
        sda_h = 1'b0; wait_q();
        scl_h = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_h = 1'b0; wait_q();
        scl_h = 1'b1; wait_q();
        sda_h = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_h = b;    wait_q();
        scl_h = 1'b1; wait_q(); wait_q();
        scl_h = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_h = 1'b1; wait_q();
        scl_h = 1'b1; wait_q();
        b = sda_line; wait_q();
        scl_h = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(r);
        acked = ~r;
    endtask

    task automatic recv_byte(input logic host_ack, output logic [7:0] d);
        logic [7:0] t;
        for (int i = 7; i >= 0; i--) read_bit(t[i]);
        write_bit(~host_ack);
        d = t;
    endtask

    task automatic compare_strobes();
        chk("strobe_count", 32'(got_q.size() - got_seen), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_seen + i < got_q.size()) begin
                chk("wr_addr", 32'(got_q[got_seen+i][15:8]), 32'(exp_q[i][15:8]));
                chk("wr_data", 32'(got_q[got_seen+i][7:0]),  32'(exp_q[i][7:0]));
                chk("strobe_1clk", 32'(got_q[got_seen+i][16]), 32'd0);
            end
        end
        got_seen = got_q.size();
        exp_q.delete();
    endtask

    // Write transaction: tx_q[0] is the pointer, the rest are data bytes.
    task automatic txn_write(input logic [6:0] a, input logic do_stop);
        logic ack, match;
        match = (a == DEFAULT_ADDR);
        i2c_start();
        send_byte({a, 1'b0}, ack);
        chk("addr_ack", 32'(ack), 32'(match));
        chk("busy_after_addr", 32'(busy), 32'(match));
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], ack);
            chk("byte_ack", 32'(ack), 32'(match));
            if (match) begin
                if (i == 0) begin
                    model_ptr = tx_q[0];
                end else begin
                    exp_q.push_back({model_ptr, tx_q[i]});
                    model_mem[model_ptr] = tx_q[i];
                    model_ptr = model_ptr + 8'd1;
                end
            end
        end
        chk("rd_addr_ptr", 32'(rd_addr), 32'(model_ptr));
        if (do_stop) begin
            i2c_stop();
            chk("busy_after_stop", 32'(busy), 32'd0);
        end
        compare_strobes();
        $display("txn write addr=0x%02h bytes=%0d ptr_now=0x%02h", a, tx_q.size(), model_ptr);
    endtask

    // Read transaction of n bytes, host NACKs the last one.
    task automatic txn_read(input logic [6:0] a, input int n);
        logic ack, match;
        logic [7:0] d;
        match = (a == DEFAULT_ADDR);
        i2c_start();
        send_byte({a, 1'b1}, ack);
        chk("rd_addr_ack", 32'(ack), 32'(match));
        if (match) begin
            for (int k = 0; k < n; k++) begin
                recv_byte(k < n - 1, d);
                chk("rd_byte", 32'(d), 32'(model_mem[model_ptr]));
                if (k < n - 1) model_ptr = model_ptr + 8'd1;
            end
            chk("busy_after_nack", 32'(busy), 32'd0);
            chk("state_wait_stop", 32'(dut.state_reg), 32'(ST_WAIT_STOP));
            chk("rd_addr_after_read", 32'(rd_addr), 32'(model_ptr));
        end else begin
            chk("busy_nomatch_rd", 32'(busy), 32'd0);
        end
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);
        compare_strobes();
        $display("txn read addr=0x%02h bytes=%0d ptr_now=0x%02h", a, n, model_ptr);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) model_mem[i] = seed_val(8'(i));

        // Reset values while reset is held.
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        $display("txn reset done");

        // Write 0x10 <- 0xAB, 0xCD.
        tx_q = '{8'h10, 8'hAB, 8'hCD};
        txn_write(7'h52, 1'b1);

        // Put 0x5A at register 3, then pointer write + repeated START read.
        tx_q = '{8'h03, 8'h5A};
        txn_write(7'h52, 1'b1);
        tx_q = '{8'h03};
        txn_write(7'h52, 1'b0);
        txn_read(7'h52, 1);

        // Address mismatch: nothing acknowledged, no strobes.
        tx_q = '{8'h20, 8'h77};
        txn_write(7'h53, 1'b1);

        // Pointer wrap.
        tx_q = '{8'hFF, 8'h11, 8'h22};
        txn_write(7'h52, 1'b1);

        // Reset asserted during the address ACK bit.
        i2c_start();
        b = 8'hA4;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_h = 1'b1; wait_q();
        scl_h = 1'b1; wait_q();
        chk("ack_before_rst", 32'(sda_oe), 32'd1);
        @(posedge clk);
        #10 rst_n = 1'b0;
        #1;
        chk("rst_async_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #10 rst_n = 1'b1;
        wait_q();
        scl_h = 1'b0; wait_q();
        i2c_stop();
        model_ptr = 8'h00;
        chk("rd_addr_after_rst", 32'(rd_addr), 32'd0);
        $display("txn reset during ack");
        tx_q = '{8'h40, 8'h99, 8'h88};
        txn_write(7'h52, 1'b1);

`ifdef PMOD_I2C_TARGET_GLITCH_FILTER_EN
        // One-clk SCL spike during the address byte must not be sampled.
        i2c_start();
        b = 8'hA4;
        for (int i = 7; i >= 4; i--) write_bit(b[i]);
        scl_h = 1'b1;
        @(posedge clk);
        #1 scl_h = 1'b0;
        wait_q();
        for (int i = 3; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
        chk("glitch_addr_ack", 32'(~ack), 32'd1);
        i2c_stop();
        $display("txn scl glitch");
`endif

        // Randomized transactions at a faster SCL.
        q_clk = 8;
        for (int t = 0; t < 20; t++) begin
            logic [6:0] a;
            int kind, n;
            a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h52;
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            if (kind == 2) begin
                txn_read(a, n);
            end else begin
                tx_q.delete();
                tx_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom));
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
                if (kind == 1 && a == 7'h52) begin
                    tx_q = '{tx_q[0]};
                    txn_write(a, 1'b0);
                    txn_read(a, n);
                end else begin
                    txn_write(a, 1'b1);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
